// File: rtl/riscv_clmul_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_clmul_unit : iterative carry-less multiplier (CLMUL/CLMULH/CLMULR),  |
// | STEP rs2 bits per cycle. Optional macro: RISCV_CLMUL_EARLY_EXIT_EN.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_clmul_unit #(
   parameter int WIDTH = 64,
   parameter int STEP  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs1,
   input  logic [WIDTH-1:0] rs2,
   input  logic             kill,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int c_CHUNKS = WIDTH / STEP;
   localparam int c_CNT_W  = $clog2(c_CHUNKS) + 1;
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_next;
   logic [1:0]           r_op;
   logic [2*WIDTH-1:0]   r_rs1_sh;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic [WIDTH-1:0]     r_rs2;
   logic [WIDTH-1:0]     w_rs2_next;
   logic [WIDTH-1:0]     r_result;
   logic [WIDTH-1:0]     w_sel;
   logic [c_CNT_W-1:0]   r_cnt;
   logic                 w_last;
   logic                 w_finish;
   logic                 w_accept;

   assign w_accept   = (r_state == S_IDLE) && in_valid && !kill;
   assign w_last     = (r_cnt == c_LAST);
   assign w_rs2_next = r_rs2 >> STEP;

`ifdef RISCV_CLMUL_EARLY_EXIT_EN
   // Stop as soon as no set rs2 bits remain beyond the chunk just processed.
   assign w_finish = w_last || (w_rs2_next == '0);
`else
   assign w_finish = w_last;
`endif

   // One chunk: r_rs1_sh already carries rs1 shifted to the chunk's base bit.
   always_comb begin
      w_acc_next = r_acc;
      for (int j = 0; j < STEP; j++) begin
         if (r_rs2[j]) begin
            w_acc_next = w_acc_next ^ (r_rs1_sh << j);
         end
      end
   end

   always_comb begin
      case (r_op)
         2'b01:   w_sel = w_acc_next[2*WIDTH-1:WIDTH];
         2'b10:   w_sel = w_acc_next[2*WIDTH-2:WIDTH-1];
         default: w_sel = w_acc_next[WIDTH-1:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (kill) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_CALC;
            S_CALC:  if (w_finish) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op     <= 2'b00;
         r_rs1_sh <= '0;
         r_rs2    <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_op     <= op;
         r_rs1_sh <= {{WIDTH{1'b0}}, rs1};
         r_rs2    <= rs2;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if ((r_state == S_CALC) && !kill) begin
         r_acc    <= w_acc_next;
         r_rs1_sh <= r_rs1_sh << STEP;
         r_rs2    <= w_rs2_next;
         r_cnt    <= r_cnt + 1'b1;
         if (w_finish) begin
            r_result <= w_sel;
         end
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);
   assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_clmul_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_clmul_unit : scoreboard bench for riscv_clmul_unit (64/4).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_riscv_clmul_unit;

   localparam int WIDTH = 64;
   localparam int STEP  = 4;

   typedef struct {
      logic [WIDTH-1:0] res;
      int               lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs1;
   logic [WIDTH-1:0] rs2;
   logic             kill;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   riscv_clmul_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs1(rs1), .rs2(rs2), .kill(kill), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] clmul_ref(input logic [1:0] o,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] p;
      p = '0;
      for (int i = 0; i < WIDTH; i++)
         if (b[i]) p = p ^ ({{WIDTH{1'b0}}, a} << i);
      case (o)
         2'b01:   return p[2*WIDTH-1:WIDTH];
         2'b10:   return p[2*WIDTH-2:WIDTH-1];
         default: return p[WIDTH-1:0];
      endcase
   endfunction

   function automatic int lat_ref(input logic [WIDTH-1:0] b);
`ifdef RISCV_CLMUL_EARLY_EXIT_EN
      int msb;
      msb = -1;
      for (int i = 0; i < WIDTH; i++) if (b[i]) msb = i;
      if (msb < 0) return 1;
      return (msb + STEP) / STEP;
`else
      return WIDTH / STEP;
`endif
   endfunction

   // Issue one request, check latency/result from the scoreboard, hold the
   // result for 'hold' cycles, then complete the handshake.
   task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input int hold,
                         input string name);
      exp_t e;
      exp_t got;
      int   lat;
      logic [WIDTH-1:0] held;
      @(negedge clk);
      in_valid = 1'b1; op = o; rs1 = a; rs2 = b; out_ready = 1'b0;
      e.res = clmul_ref(o, a, b);
      e.lat = lat_ref(b);
      sb_q.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0; op = 2'($urandom); rs1 = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      got = sb_q.pop_front();
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL %s timeout: out_valid=%b after %0d edges, required 1", name, out_valid, lat);
         return;
      end
      checks++;
      if (lat !== got.lat) begin
         errors++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, got.lat);
      end
      checks++;
      if (result !== got.res) begin
         errors++;
         $display("FAIL %s result: got %h required %h", name, result, got.res);
      end
      held = result;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== held || !out_valid || in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s hold%0d: result=%h ov=%b ir=%b busy=%b required %h 1 0 1",
                     name, k, result, out_valid, in_ready, busy, held);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s handshake: ir=%b ov=%b busy=%b required 1 0 0",
                  name, in_ready, out_valid, busy);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
      kill = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== '0) begin
         errors++;
         $display("FAIL reset: ir=%b ov=%b busy=%b result=%h required 1 0 0 0",
                  in_ready, out_valid, busy, result);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ops();
      run_op(2'b00, 64'h3, 64'h3, 0, "clmul_3x3");
      run_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, "clmulh_msb");
      run_op(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, "clmulr_msb");
      run_op(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, "clmul_msb");
      run_op(2'b11, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_1111_0003, 0, "reserved_op");
      run_op(2'b00, 64'hDEAD_BEEF_0000_0001, 64'h1, 0, "rs2_one");
      run_op(2'b01, 64'hDEAD_BEEF_0000_0001, 64'h10, 0, "rs2_0x10");
      run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, "rs2_zero");
   endtask

   task automatic test_backpressure();
      run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 5, "backpressure");
   endtask

   task automatic test_kill();
      int seen;
      @(negedge clk);
      in_valid = 1'b1; op = 2'b01; rs1 = 64'hFFFF_0000_FFFF_0000; rs2 = 64'h8000_0000_0000_0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL kill_idle: ir=%b ov=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
      end
      @(negedge clk);
      kill = 1'b0;
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL kill_no_valid: out_valid cycles=%0d required 0", seen);
      end
      run_op(2'b00, 64'h0000_0000_0000_00F5, 64'h0000_0000_0000_0033, 0, "after_kill");
   endtask

   task automatic test_reset_in_done();
      int lat;
      @(negedge clk);
      in_valid = 1'b1; op = 2'b00; rs1 = 64'hF; rs2 = 64'h3; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1 || result !== 64'h11) begin
         errors++;
         $display("FAIL rst_done_pre: ov=%b result=%h required 1 0000000000000011", out_valid, result);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || result !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rst_done: ov=%b result=%h ir=%b busy=%b required 0 0 1 0",
                  out_valid, result, in_ready, busy);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 6; n++)
         run_op(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, 0, "b2b_rand");
   endtask

   initial begin
      test_reset();
      test_ops();
      test_backpressure();
      test_kill();
      test_reset_in_done();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/riscv_clmul_unit.md
RISCV_CLMUL_UNIT -- requirements
Module: riscv_clmul_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the operand and result width; it SHALL be a power of two, 32 or 64.
REQ-002 SHALL have parameter STEP, default 4, giving the rs2 bits processed per cycle; it SHALL be a power of two that divides WIDTH.
REQ-003 SHALL use one clock and a synchronous active-high reset, with ports as below.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept; high only in IDLE.
REQ-008 op  input  2  00 CLMUL, 01 CLMULH, 10 CLMULR, 11 reserved (executes as CLMUL).
REQ-009 rs1, rs2  input  WIDTH  operands.
REQ-010 kill  input  1  abort any operation in flight.
REQ-011 out_valid  output  1  result available; high only in DONE.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  WIDTH  carry-less result.
REQ-014 busy  output  1  high in CALC or DONE.

Function
REQ-015 The full product SHALL be P[2*WIDTH-1:0], the XOR over all i with rs2[i]=1 of (rs1 << i); P[2*WIDTH-1] is always 0.
REQ-016 Result SHALL be P[WIDTH-1:0] for CLMUL, P[2*WIDTH-1:WIDTH] for CLMULH and P[2*WIDTH-2:WIDTH-1] for CLMULR.
REQ-017 The FSM SHALL have three states, IDLE, CALC and DONE, with the transitions below.
REQ-018 IDLE->CALC on an edge with in_valid&in_ready&!kill; op, rs1 and rs2 SHALL be latched at that edge, and later input changes SHALL be ignored.
REQ-019 In CALC, each edge SHALL process the next STEP bits of rs2, starting with the least-significant bits; the accumulator SHALL be 2*WIDTH bits wide with no truncation.
REQ-020 CALC->DONE on the edge that processes the final chunk; latency L SHALL be counted in edges from the accepting edge (exclusive) to the first cycle with out_valid=1.
REQ-021 DONE->IDLE on an edge with out_ready=1; while out_valid=1 and out_ready=0, result SHALL stay stable.
REQ-022 in_ready SHALL be 0 in CALC and DONE, so no accept can coincide with a result handshake.
REQ-023 kill=1 SHALL force IDLE at the next edge from any state and discard the result.
REQ-024 kill SHALL take priority over in_valid and over out_ready; no accept and no result handshake occurs on a kill edge.
REQ-025 result SHALL retain its last value outside DONE and SHALL be meaningful only when out_valid=1.

Reset
REQ-026 rst SHALL take priority over kill and all other inputs, in any state.
REQ-027 On a reset edge: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0 and accumulator=0.
REQ-028 Reset mid-CALC or mid-DONE SHALL drop the operation, and no out_valid SHALL follow it.

Configuration
REQ-029 Macro RISCV_CLMUL_EARLY_EXIT_EN SHALL control early exit from CALC.
REQ-030 Without the macro, L SHALL be exactly WIDTH/STEP for every operand value.
REQ-031 With the macro, CALC->DONE SHALL occur on the first CALC edge after which all unprocessed rs2 bits are zero.
REQ-032 With the macro, L = max(1, ceil((msb_index(rs2)+1)/STEP)); rs2=0 SHALL give L=1 and result=0.
REQ-033 Result values SHALL be identical with and without the macro.

Verification (WIDTH=64, STEP=4)
REQ-034 CLMUL rs1=0x3, rs2=0x3 -> result 0x5; without the macro out_valid rises with L=16.
REQ-035 rs1=rs2=0x8000_0000_0000_0000: CLMULH -> 0x4000_0000_0000_0000; CLMULR -> 0x8000_0000_0000_0000; CLMUL -> 0x0.
REQ-036 CLMUL rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=0x3, with out_ready held 0 for 5 cycles after out_valid -> result 0x0000_0000_0000_0001 stable throughout, in_ready=0 and busy=1, then IDLE one edge after out_ready=1.
REQ-037 kill asserted on the 5th CALC cycle -> IDLE with in_ready=1 at the next edge and no out_valid; a new request is then accepted normally.
REQ-038 With the macro: rs2=0x1 -> L=1; rs2=0x10 -> L=2; rs2=0 -> L=1 with result 0; rs2=0x8000_0000_0000_0000 -> L=16.
REQ-039 rst asserted in DONE with out_ready=0 -> next cycle out_valid=0, result=0, in_ready=1.
